// File: rtl/cgra_seq_pkg.sv
// Shared types and defaults for the CGRA execution sequencer.
package cgra_seq_pkg;

    // Default width of cycle counters and the watchdog limit
    localparam int unsigned CNT_W_DEFAULT = 32;

    // Sequencer phases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CFG   = 2'd1,
        CLEAR = 2'd2,
        EXEC  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/cgra_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module cgra_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_count;

    // Clear has priority; counting stops at all-ones instead of wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cgra_exec_sequencer.sv
// Sequences CGRA configuration load, state clear and kernel execution,
// with per-output completion tracking, watchdog, abort and perf counters.
module cgra_exec_sequencer
    import cgra_seq_pkg::*;
#(
    parameter int unsigned N_IN         = 4,
    parameter int unsigned N_OUT        = 4,
    parameter int unsigned CNT_W        = CNT_W_DEFAULT,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_configuration_i,
    input  logic             start_execution_i,
    input  logic             abort_i,
    input  logic [N_OUT-1:0] out_enable_mask_i,
    input  logic [CNT_W-1:0] timeout_cycles_i,
    input  logic             config_done_i,
    input  logic [N_OUT-1:0] out_done_i,
    input  logic [N_IN-1:0]  read_stall_i,
    input  logic             write_stall_i,
    output logic             execute_config_o,
    output logic             execute_input_o,
    output logic             execute_output_o,
    output logic             clear_cgra_state_o,
    output logic             busy_o,
    output logic             done_config_o,
    output logic             done_exec_o,
    output logic             error_timeout_o,
    output logic [CNT_W-1:0] cycle_count_load_config_o,
    output logic [CNT_W-1:0] cycle_count_execute_o,
    output logic [CNT_W-1:0] cycle_count_stall_o
);

    localparam int unsigned      CLR_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic             r_pending_exec;
    logic [CLR_W-1:0] r_clr_cnt;
    logic [N_OUT-1:0] r_mask;
    logic [N_OUT-1:0] r_done_mask;
    logic             r_done_cfg;
    logic             r_done_exec;
    logic             r_err_timeout;

    logic             w_idle;
    logic             w_in_cfg;
    logic             w_in_clear;
    logic             w_in_exec;
    logic             w_load_acc;
    logic             w_cfg_done;
    logic             w_exec_clear;
    logic             w_clr_last;
    logic             w_complete;
    logic             w_timeout;
    logic             w_stall;
    logic [CNT_W-1:0] w_exec_cnt;

    assign w_idle     = (r_state == IDLE);
    assign w_in_cfg   = (r_state == CFG);
    assign w_in_clear = (r_state == CLEAR);
    assign w_in_exec  = (r_state == EXEC);

    assign w_load_acc   = w_idle & load_configuration_i;
    assign w_cfg_done   = w_in_cfg & config_done_i & ~abort_i;
    // Exec flags/counters restart on a direct start or on a chained CFG->CLEAR hand-off
    assign w_exec_clear = (w_idle & start_execution_i) | (w_cfg_done & r_pending_exec);
    assign w_clr_last   = (r_clr_cnt == CLR_LAST);
    // Unmasked outputs count as finished; a same-cycle done pulse completes immediately
    assign w_complete   = w_in_exec & (&(r_done_mask | out_done_i | ~r_mask));
    assign w_timeout    = w_in_exec & (timeout_cycles_i != '0)
                        & (w_exec_cnt == (timeout_cycles_i - CNT_ONE));
    assign w_stall      = (|read_stall_i) | write_stall_i;

    // Next-state selection; abort outranks config_done, completion and timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (load_configuration_i) begin
                    w_state_nxt = CFG;
                end else if (start_execution_i) begin
                    w_state_nxt = CLEAR;
                end
            end
            CFG: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (config_done_i) begin
                    w_state_nxt = r_pending_exec ? CLEAR : IDLE;
                end
            end
            CLEAR: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (w_clr_last) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (abort_i || w_complete || w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Chained-execution request: set by load+start together, dropped when CFG ends
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending_exec <= 1'b0;
        end else if (w_idle) begin
            r_pending_exec <= load_configuration_i & start_execution_i;
        end else if (w_in_cfg && (abort_i || config_done_i)) begin
            r_pending_exec <= 1'b0;
        end
    end

    // Clear-phase timer, zero outside CLEAR
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_clr_cnt <= '0;
        end else if (w_in_clear && !w_clr_last) begin
            r_clr_cnt <= r_clr_cnt + CLR_ONE;
        end else begin
            r_clr_cnt <= '0;
        end
    end

    // Output enable mask, captured on entry to EXEC
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mask <= '0;
        end else if (w_in_clear && w_clr_last && !abort_i) begin
            r_mask <= out_enable_mask_i;
        end
    end

    // Accumulated per-output completion during EXEC
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done_mask <= '0;
        end else if (w_exec_clear) begin
            r_done_mask <= '0;
        end else if (w_in_exec) begin
            r_done_mask <= r_done_mask | (out_done_i & r_mask);
        end
    end

    // Sticky status flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done_cfg    <= 1'b0;
            r_done_exec   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_load_acc) begin
                r_done_cfg <= 1'b0;
            end else if (w_cfg_done) begin
                r_done_cfg <= 1'b1;
            end
            if (w_exec_clear) begin
                r_done_exec   <= 1'b0;
                r_err_timeout <= 1'b0;
            end else if (w_in_exec && !abort_i) begin
                if (w_complete) begin
                    r_done_exec <= 1'b1;
                end else if (w_timeout) begin
                    r_err_timeout <= 1'b1;
                end
            end
        end
    end

    cgra_sat_counter #(.W(CNT_W)) u_cnt_load (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (w_load_acc),
        .i_en    (w_in_cfg),
        .o_count (cycle_count_load_config_o)
    );

    cgra_sat_counter #(.W(CNT_W)) u_cnt_exec (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (w_exec_clear),
        .i_en    (w_in_exec),
        .o_count (w_exec_cnt)
    );

    cgra_sat_counter #(.W(CNT_W)) u_cnt_stall (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (w_exec_clear),
        .i_en    (w_in_exec & w_stall),
        .o_count (cycle_count_stall_o)
    );

    assign cycle_count_execute_o = w_exec_cnt;
    assign execute_config_o      = w_in_cfg;
    assign execute_input_o       = w_in_exec;
    assign execute_output_o      = w_in_exec;
    assign clear_cgra_state_o    = w_in_clear;
    assign busy_o                = ~w_idle;
    assign done_config_o         = r_done_cfg;
    assign done_exec_o           = r_done_exec;
    assign error_timeout_o       = r_err_timeout;

endmodule

// File: tb/tb_cgra_exec_sequencer.sv
// Randomised operation-level bench for cgra_exec_sequencer (CNT_W=8, CLEAR_CYCLES=2).
module tb_cgra_exec_sequencer;

    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int CNT_W = 8;
    localparam int CLR   = 2;
    localparam int BIG   = 1000000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0, start = 1'b0, abort = 1'b0, cfg_done = 1'b0, wstall = 1'b0;
    logic [N_OUT-1:0] mask = '0, odone = '0;
    logic [N_IN-1:0]  rstall = '0;
    logic [CNT_W-1:0] tmo = '0;
    logic             ex_cfg, ex_in, ex_out, clr_st, busy, d_cfg, d_exec, err_to;
    logic [CNT_W-1:0] c_load, c_exec, c_stall;

    always #5 clk = ~clk;

    cgra_exec_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W), .CLEAR_CYCLES(CLR)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .load_configuration_i(load), .start_execution_i(start), .abort_i(abort),
        .out_enable_mask_i(mask), .timeout_cycles_i(tmo), .config_done_i(cfg_done),
        .out_done_i(odone), .read_stall_i(rstall), .write_stall_i(wstall),
        .execute_config_o(ex_cfg), .execute_input_o(ex_in), .execute_output_o(ex_out),
        .clear_cgra_state_o(clr_st), .busy_o(busy), .done_config_o(d_cfg),
        .done_exec_o(d_exec), .error_timeout_o(err_to),
        .cycle_count_load_config_o(c_load), .cycle_count_execute_o(c_exec),
        .cycle_count_stall_o(c_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Operation description
    bit       op_load, op_start;
    int       op_lat, op_cfg_ab, op_clr_ab, op_tmo, op_ex_ab;
    logic [3:0] op_mask;
    int       op_done_at [4];
    logic [4:0] op_stall [0:1099];

    // Expected architectural state carried across operations
    int e_load = 0, e_exec = 0, e_stall = 0;
    bit e_dcfg = 0, e_dexec = 0, e_err = 0;

    task automatic drive_idle();
        load = 0; start = 0; abort = 0; cfg_done = 0; odone = '0; rstall = '0; wstall = 0;
    endtask

    // Predict phase lengths and final results from the operation description, then
    // drive it cycle by cycle on the bench's own timeline and compare the outcome.
    task automatic run_op();
        int cfg_dur, clr_dur, ex_dur, total, ec, ea, et, endi, v, s, idx;
        int n_cfg, n_clr, n_ex, n_busy, n_io;
        bit cfg_ok, go_exec;
        logic [3:0] od;
        cfg_dur = 0; clr_dur = 0; ex_dur = 0; cfg_ok = 1;
        if (op_load) begin
            if (op_cfg_ab >= 0 && op_cfg_ab < op_lat) begin
                cfg_dur = op_cfg_ab + 1; cfg_ok = 0;
            end else begin
                cfg_dur = op_lat;
            end
            e_load = sat(cfg_dur);
            e_dcfg = cfg_ok;
        end
        if (op_start) begin
            e_exec = 0; e_stall = 0; e_dexec = 0; e_err = 0;
        end
        go_exec = op_start && cfg_ok;
        if (go_exec) begin
            if (op_clr_ab >= 0 && op_clr_ab < CLR) begin
                clr_dur = op_clr_ab + 1;
            end else begin
                clr_dur = CLR;
                ec = 0;
                for (int i = 0; i < 4; i++) begin
                    if (op_mask[i]) begin
                        v = (op_done_at[i] < 0) ? BIG : op_done_at[i];
                        if (v > ec) ec = v;
                    end
                end
                ea = (op_ex_ab < 0) ? BIG : op_ex_ab;
                et = (op_tmo == 0) ? BIG : op_tmo - 1;
                endi = ec;
                if (ea < endi) endi = ea;
                if (et < endi) endi = et;
                ex_dur = endi + 1;
                s = 0;
                for (int e = 0; e < ex_dur; e++) if (op_stall[e] != 0) s++;
                e_exec  = sat(ex_dur);
                e_stall = sat(s);
                e_dexec = (ea != endi) && (ec == endi);
                e_err   = (ea != endi) && (ec != endi) && (et == endi);
            end
        end
        total = cfg_dur + clr_dur + ex_dur;

        @(negedge clk);
        mask = op_mask; tmo = CNT_W'(op_tmo);
        load = op_load; start = op_start;
        n_cfg = 0; n_clr = 0; n_ex = 0; n_busy = 0; n_io = 0;
        for (int k = 0; k < total + 3; k++) begin
            @(negedge clk);
            n_cfg  += int'(ex_cfg);
            n_clr  += int'(clr_st);
            n_ex   += int'(ex_in);
            n_busy += int'(busy);
            if (ex_in != ex_out) n_io++;
            drive_idle();
            if (k < cfg_dur) begin
                cfg_done = (k == op_lat - 1);
                abort    = (k == op_cfg_ab);
            end else if (k < cfg_dur + clr_dur) begin
                idx   = k - cfg_dur;
                abort = (idx == op_clr_ab);
                mask  = 4'($urandom) ^ op_mask;
                if (idx == CLR - 1) mask = op_mask;
            end else if (k < total) begin
                idx = k - cfg_dur - clr_dur;
                mask = 4'($urandom);
                od = 4'($urandom) & ~op_mask;
                for (int i = 0; i < 4; i++)
                    if (op_mask[i] && op_done_at[i] == idx) od[i] = 1'b1;
                odone = od;
                {rstall, wstall} = op_stall[idx];
                abort = (idx == op_ex_ab);
            end
            if (k < total && $urandom_range(0, 7) == 0) load = 1;
            if (k < total && $urandom_range(0, 7) == 0) start = 1;
        end
        check_eq("cfg_len",    n_cfg,  cfg_dur);
        check_eq("clear_len",  n_clr,  clr_dur);
        check_eq("exec_len",   n_ex,   ex_dur);
        check_eq("busy_len",   n_busy, total);
        check_eq("in_out_eq",  n_io,   0);
        check_eq("done_cfg",   int'(d_cfg),  int'(e_dcfg));
        check_eq("done_exec",  int'(d_exec), int'(e_dexec));
        check_eq("err_tmo",    int'(err_to), int'(e_err));
        check_eq("cnt_load",   int'(c_load),  e_load);
        check_eq("cnt_exec",   int'(c_exec),  e_exec);
        check_eq("cnt_stall",  int'(c_stall), e_stall);
    endtask

    task automatic clear_op();
        op_load = 0; op_start = 0; op_lat = 1; op_cfg_ab = -1; op_clr_ab = -1;
        op_tmo = 0; op_ex_ab = -1; op_mask = '0;
        for (int i = 0; i < 4; i++) op_done_at[i] = -1;
        for (int e = 0; e < 1100; e++) op_stall[e] = '0;
    endtask

    task automatic random_op();
        clear_op();
        case ($urandom_range(0, 2))
            0: op_load = 1;
            1: op_start = 1;
            default: begin op_load = 1; op_start = 1; end
        endcase
        op_lat = $urandom_range(1, 12);
        if ($urandom_range(0, 4) == 0) op_cfg_ab = $urandom_range(0, op_lat - 1);
        if ($urandom_range(0, 7) == 0) op_clr_ab = $urandom_range(0, CLR - 1);
        op_mask = 4'($urandom);
        for (int i = 0; i < 4; i++)
            op_done_at[i] = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 20);
        op_tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
        if ($urandom_range(0, 5) == 0) op_ex_ab = $urandom_range(0, 25);
        if (op_tmo == 0 && op_ex_ab < 0) op_ex_ab = 30;
        for (int e = 0; e < 64; e++)
            op_stall[e] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
    endtask

    initial begin
        drive_idle();
        repeat (3) @(negedge clk);
        check_eq("rst_busy",     int'(busy),    0);
        check_eq("rst_cfg_out",  int'(ex_cfg),  0);
        check_eq("rst_clear",    int'(clr_st),  0);
        check_eq("rst_exec_out", int'(ex_in),   0);
        check_eq("rst_flags",    int'({d_cfg, d_exec, err_to}), 0);
        check_eq("rst_counts",   int'(c_load) + int'(c_exec) + int'(c_stall), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Config load with config_done on its 10th cycle
        clear_op(); op_load = 1; op_lat = 10; run_op();
        // Mask 0101, out_done[0] at EXEC index 5, [2] at 8, [1] never
        clear_op(); op_start = 1; op_mask = 4'b0101;
        op_done_at[0] = 5; op_done_at[2] = 8; run_op();
        // Chained load+start
        clear_op(); op_load = 1; op_start = 1; op_lat = 6; op_mask = 4'b1000;
        op_done_at[3] = 3; run_op();
        // Watchdog of 20 cycles with no completion
        clear_op(); op_start = 1; op_mask = 4'b1111; op_tmo = 20; run_op();
        // Abort on third EXEC cycle, then a fresh start with an empty mask
        clear_op(); op_start = 1; op_mask = 4'b0011; op_ex_ab = 2; run_op();
        clear_op(); op_start = 1; op_mask = 4'b0000; op_tmo = 1; run_op();
        // Completion and timeout on the same cycle
        clear_op(); op_start = 1; op_mask = 4'b0010; op_done_at[1] = 4; op_tmo = 5; run_op();
        // Abort on the same cycle as config_done
        clear_op(); op_load = 1; op_start = 1; op_lat = 4; op_cfg_ab = 3; run_op();
        // Long write stall saturates both exec counters
        clear_op(); op_start = 1; op_mask = 4'b0001; op_ex_ab = 999;
        for (int e = 0; e < 1000; e++) op_stall[e] = 5'b00001;
        run_op();

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); abort = 1;
                @(negedge clk); abort = 0;
                check_eq("idle_abort", int'({busy, d_cfg, d_exec, err_to}),
                         int'({1'b0, e_dcfg, e_dexec, e_err}));
            end
            random_op();
            run_op();
        end

        // Asynchronous reset in the middle of EXEC
        clear_op(); op_load = 1; op_lat = 3; run_op();
        @(negedge clk); mask = 4'b1111; tmo = '0; start = 1;
        @(negedge clk); start = 0;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_busy",   int'(busy), 0);
        check_eq("arst_flags",  int'({d_cfg, d_exec, err_to}), 0);
        check_eq("arst_counts", int'(c_load) + int'(c_exec) + int'(c_stall), 0);
        @(negedge clk); rst_n = 1'b1;
        e_load = 0; e_exec = 0; e_stall = 0; e_dcfg = 0; e_dexec = 0; e_err = 0;
        clear_op(); op_start = 1; op_mask = 4'b0100; op_done_at[2] = 2; run_op();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
